// File: rtl/phase_ramp_gen_v5.sv
// Serrodyne phase-ramp generator: fractional accumulator with power-of-two gain, hold mode and 2pi-wrap reporting.
// Optional net wrap counter is compiled in with PHASE_RAMP_WRAP_CNT_EN.
module phase_ramp_gen_v5 #(
    parameter int OUTPUT_BIT = 16,
    parameter int ACC_BIT    = 32,
    parameter int SHIFT_BIT  = 4,
    parameter int CNT_BIT    = 16,
    parameter int RST_SHIFT  = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_trig,
    input  logic signed [OUTPUT_BIT-1:0] i_step,
    input  logic                         i_fb_on,
    input  logic                         i_hold,
    input  logic signed [OUTPUT_BIT-1:0] i_mod,
    input  logic        [SHIFT_BIT-1:0]  i_gain_sel,
    output logic signed [OUTPUT_BIT-1:0] o_ladderWave,
    output logic signed [OUTPUT_BIT-1:0] o_phaseRamp,
    output logic                         o_wrap_up,
    output logic                         o_wrap_dn,
    output logic signed [CNT_BIT-1:0]    o_wrap_cnt,
    output logic        [SHIFT_BIT-1:0]  o_shift,
    output logic        [1:0]            o_state
);

    localparam int FRAC = ACC_BIT - OUTPUT_BIT;
    localparam int SA_W = $clog2(FRAC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_BIT-1:0]   acc_q, acc_d;
    logic        [SHIFT_BIT-1:0] shift_q, shift_d;
    logic                        wrap_up_q, wrap_up_d;
    logic                        wrap_dn_q, wrap_dn_d;
    logic signed [OUTPUT_BIT-1:0] phase_q, phase_d;

    logic        [SHIFT_BIT-1:0] shift_eff;
    logic        [SA_W-1:0]      shift_amt;
    logic signed [ACC_BIT-1:0]   step_ext;
    logic signed [ACC_BIT-1:0]   incr;
    logic signed [ACC_BIT-1:0]   acc_sum;
    logic signed [OUTPUT_BIT-1:0] ladder;

    // The increment is always formed with the gain that will be active after the edge
    always_comb begin
        if (int'(i_gain_sel) > FRAC) shift_eff = SHIFT_BIT'(FRAC);
        else                         shift_eff = i_gain_sel;
        shift_amt = SA_W'(FRAC - int'(shift_eff));
        step_ext  = {{FRAC{i_step[OUTPUT_BIT-1]}}, i_step};
        incr      = step_ext <<< shift_amt;
        acc_sum   = acc_q + incr;
    end

    assign ladder  = acc_q[ACC_BIT-1 -: OUTPUT_BIT];
    assign phase_d = ladder + i_mod;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        shift_d   = shift_q;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        if (!i_fb_on) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            shift_d = shift_eff;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_HOLD: begin
                    shift_d = shift_eff;
                    state_d = i_hold ? ST_HOLD : ST_RUN;
                end
                ST_RUN: begin
                    if (i_hold) begin
                        state_d = ST_HOLD;
                    end else if (i_trig) begin
                        acc_d     = acc_sum;
                        shift_d   = shift_eff;
                        wrap_up_d = !incr[ACC_BIT-1] && !acc_q[ACC_BIT-1] &&  acc_sum[ACC_BIT-1];
                        wrap_dn_d =  incr[ACC_BIT-1] &&  acc_q[ACC_BIT-1] && !acc_sum[ACC_BIT-1];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            shift_q   <= SHIFT_BIT'(RST_SHIFT);
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
            phase_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            shift_q   <= shift_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
            phase_q   <= phase_d;
        end
    end

`ifdef PHASE_RAMP_WRAP_CNT_EN
    localparam logic signed [CNT_BIT-1:0] CNT_MAX = {1'b0, {(CNT_BIT-1){1'b1}}};
    localparam logic signed [CNT_BIT-1:0] CNT_MIN = {1'b1, {(CNT_BIT-1){1'b0}}};

    logic signed [CNT_BIT-1:0] cnt_q;

    // Counter moves on the same edge that registers the wrap pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (!i_fb_on || state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (wrap_up_d && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_BIT'(1);
        end else if (wrap_dn_d && cnt_q != CNT_MIN) begin
            cnt_q <= cnt_q - CNT_BIT'(1);
        end
    end

    assign o_wrap_cnt = cnt_q;
`else
    assign o_wrap_cnt = '0;
`endif

    assign o_ladderWave = ladder;
    assign o_phaseRamp  = phase_q;
    assign o_wrap_up    = wrap_up_q;
    assign o_wrap_dn    = wrap_dn_q;
    assign o_shift      = shift_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_phase_ramp_gen_v5.sv
// Bench for phase_ramp_gen_v5: directed ramp/wrap cases then randomized traffic against an integer-arithmetic model.
module tb_phase_ramp_gen_v5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               trig, fb_on, hold;
    logic signed [15:0] step, mod;
    logic        [3:0]  gain;
    logic signed [15:0] ladder, phase, cnt;
    logic               up, dn;
    logic        [3:0]  shift;
    logic        [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: accumulator as a plain signed integer in [-2^31, 2^31)
    longint m_acc, m_cnt, m_phase;
    int     m_state, m_shift;
    bit     m_up, m_dn;

    localparam longint TWO32 = 64'sd4294967296;
    localparam longint HALF  = 64'sd2147483648;

`ifdef PHASE_RAMP_WRAP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    phase_ramp_gen_v5 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_step(step),
        .i_fb_on(fb_on), .i_hold(hold), .i_mod(mod), .i_gain_sel(gain),
        .o_ladderWave(ladder), .o_phaseRamp(phase), .o_wrap_up(up), .o_wrap_dn(dn),
        .o_wrap_cnt(cnt), .o_shift(shift), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint wrap16(input longint v);
        return (((v + 32768) % 65536) + 65536) % 65536 - 32768;
    endfunction

    function automatic longint m_ladder();
        return m_acc >>> 16;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_phase = 0; m_state = 0; m_shift = 5; m_up = 0; m_dn = 0;
    endtask

    task automatic model_step();
        int     fe;
        longint sum;
        fe      = (int'(gain) > 16) ? 16 : int'(gain);
        m_phase = wrap16(m_ladder() + longint'(mod));
        m_up    = 0;
        m_dn    = 0;
        if (!fb_on) begin
            m_state = 0; m_acc = 0; m_shift = fe; m_cnt = 0;
        end else if (m_state != 1) begin
            m_shift = fe;
            m_state = hold ? 2 : 1;
        end else if (hold) begin
            m_state = 2;
        end else if (trig) begin
            m_shift = fe;
            sum = m_acc + longint'(step) * (longint'(1) << (16 - fe));
            if (sum >= HALF) begin
                sum -= TWO32; m_up = 1;
            end else if (sum < -HALF) begin
                sum += TWO32; m_dn = 1;
            end
            m_acc = sum;
            if (CNT_ON && m_up && m_cnt < 32767)  m_cnt++;
            if (CNT_ON && m_dn && m_cnt > -32768) m_cnt--;
        end
    endtask

    task automatic check_all();
        chk("ladder", ladder, m_ladder());
        chk("phase",  phase,  m_phase);
        chk("wrap_up", up, longint'(m_up));
        chk("wrap_dn", dn, longint'(m_dn));
        chk("wrap_cnt", cnt, m_cnt);
        chk("shift", shift, m_shift);
        chk("state", state, m_state);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; trig = 0; fb_on = 0; hold = 0; step = 0; mod = 0; gain = 0;
        model_reset();
        #12;
        check_all();
        chk("rst_shift", shift, 5);
        rst_n = 1'b1;

        // full-scale ramp at shift 0 and positive wrap
        fb_on = 1; gain = 0; step = 16'sd1000; trig = 1;
        tick();
        repeat (32) tick();
        chk("d1_ladder_32000", ladder, 32000);
        tick();
        chk("d1_wrap_ladder", ladder, -32536);
        chk("d1_wrap_up", up, 1);
        trig = 0;
        tick();
        chk("d1_up_one_cycle", up, 0);
        chk("d1_cnt", cnt, CNT_ON ? 1 : 0);

        // feedback off clears; fractional accumulation at shift 5
        fb_on = 0;
        tick();
        chk("d2_idle_ladder", ladder, 0);
        chk("d2_idle_state", state, 0);
        chk("d2_idle_cnt", cnt, 0);
        fb_on = 1; gain = 5;
        tick();
        trig = 1; step = 16'sd1000;
        repeat (32) tick();
        chk("d2_frac_ladder", ladder, 1000);
        step = -16'sd1000;
        repeat (32) tick();
        chk("d2_frac_return", ladder, 0);

        // negative steps and negative wrap
        gain = 0; step = -16'sd1;
        tick();
        chk("d3_minus1", ladder, -1);
        chk("d3_no_dn", dn, 0);
        step = -16'sd32767;
        tick();
        chk("d3_min", ladder, -32768);
        step = -16'sd1;
        tick();
        chk("d3_wrap_ladder", ladder, 32767);
        chk("d3_wrap_dn", dn, 1);
        chk("d3_cnt", cnt, CNT_ON ? -1 : 0);

        // modulation wrap, gain held without trigger, hold freezes
        trig = 0; mod = 16'sd1;
        tick();
        tick();
        chk("d4_phase_wrap", phase, -32768);
        gain = 3;
        tick();
        chk("d4_shift_held", shift, 0);
        hold = 1; trig = 1; step = 16'sd500;
        tick();
        tick();
        chk("d4_hold_state", state, 2);
        chk("d4_hold_ladder", ladder, 32767);
        hold = 0; trig = 0;
        tick();

        // randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 4000; i++) begin
            fb_on = ($urandom_range(0, 99) < 97);
            hold  = ($urandom_range(0, 99) < 10);
            trig  = ($urandom_range(0, 99) < 60);
            step  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) step = 16'($signed(16'($urandom_range(0, 2000))) - 16'sd1000);
            mod   = 16'($urandom);
            if ($urandom_range(0, 9) == 0) gain = 4'($urandom);
            tick();
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                #2 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
